// File: rtl/pe_run_controller_pkg.sv
// Shared definitions for the PE run sequencer: FSM states and parameter defaults.
package pe_run_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] HALT_INSN_DEF = 32'h0000_0073;
  localparam int unsigned CYC_W_DEF     = 16;

endpackage

// File: rtl/pe_run_controller_if.sv
// Host program-stream handshake between the loader (master) and the run controller (slave).
interface pe_run_controller_if #(
    parameter int unsigned DATA_W = 32
);
    logic              prog_valid;
    logic              prog_ready;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;

    modport master (output prog_valid, prog_data, prog_last, input  prog_ready);
    modport slave  (input  prog_valid, prog_data, prog_last, output prog_ready);
endinterface

// File: rtl/pe_run_controller_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and a "next count reaches limit" flag.
module pe_cycle_counter #(
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CYC_W-1:0] limit_i,
    output logic [CYC_W-1:0] count_o,
    output logic             at_limit_o
);
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [CYC_W:0]   cnt_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                   cnt_d = '0;
        else if (en_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // Compared one bit wider so the increment cannot wrap; limit 0 means "no limit".
    assign cnt_inc    = {1'b0, cnt_q} + {{CYC_W{1'b0}}, 1'b1};
    assign at_limit_o = (limit_i != '0) && (cnt_inc == {1'b0, limit_i});
    assign count_o    = cnt_q;
endmodule

// File: rtl/pe_run_controller.sv
// Loads a program into PE imem, runs the PE until halt, reports status and cycle count.
// Optional watchdog enabled by defining PE_WATCHDOG_EN.
module pe_run_controller
  import pe_run_controller_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       IMEM_DEPTH = 256,
    parameter int unsigned       CYC_W      = CYC_W_DEF,
    parameter logic [DATA_W-1:0] HALT_INSN  = DATA_W'(HALT_INSN_DEF),
    localparam int unsigned      AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    pe_run_controller_if.slave  prog,
    output logic                imem_we,
    output logic [AW-1:0]       imem_waddr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                pe_rst,
    input  logic [DATA_W-1:0]   pe_instr,
    input  logic [CYC_W-1:0]    max_cycles,
    output logic                busy,
    output logic                done,
    output logic                halted_ok,
    output logic                timeout,
    output logic [CYC_W-1:0]    cycle_count
);
`ifdef PE_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          halted_q, halted_d;
    logic          timeout_q, timeout_d;
    logic          hs, halt_hit, wd_hit, at_limit, cnt_clr, cnt_en;

    pe_cycle_counter #(.CYC_W(CYC_W)) u_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .limit_i    (max_cycles),
        .count_o    (cycle_count),
        .at_limit_o (at_limit)
    );

    assign halt_hit = (pe_instr == HALT_INSN);
    assign wd_hit   = WD_EN & at_limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d   = S_LOAD;
                waddr_d   = '0;
                halted_d  = 1'b0;
                timeout_d = 1'b0;
                cnt_clr   = 1'b1;
            end
            S_LOAD: if (hs) begin
                // Address holds at the top word so a full-depth load never wraps to 0.
                if (waddr_q != LAST_ADDR) waddr_d = waddr_q + 1'b1;
                if (prog.prog_last || waddr_q == LAST_ADDR) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                if (halt_hit) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prog.prog_ready = (state_q == S_LOAD);
        hs              = prog.prog_ready & prog.prog_valid;
        imem_we         = hs;
        imem_waddr      = waddr_q;
        imem_wdata      = (state_q == S_LOAD) ? prog.prog_data : '0;
        pe_rst          = (state_q == S_RUN);
        busy            = (state_q == S_LOAD) || (state_q == S_RUN);
        done            = (state_q == S_DONE);
        halted_ok       = halted_q;
        timeout         = timeout_q;
    end
endmodule

// File: tb/tb_pe_run_controller.sv
// Randomized self-checking bench for pe_run_controller with a cycle-level reference model.
module tb_pe_run_controller;
    localparam int          DEPTH = 8;
    localparam int          CMAX  = 65535;
    localparam logic [31:0] HALT  = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;
`ifdef PE_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] max_cycles = '0;
    logic        imem_we, pe_rst, busy, done, halted_ok, timeout;
    logic [2:0]  imem_waddr;
    logic [31:0] imem_wdata, pe_instr;
    logic [15:0] cycle_count;

    pe_run_controller_if #(.DATA_W(32)) prog_if ();

    pe_run_controller #(
        .DATA_W(32), .IMEM_DEPTH(DEPTH), .CYC_W(16), .HALT_INSN(HALT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog(prog_if),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pe_rst(pe_rst), .pe_instr(pe_instr), .max_cycles(max_cycles),
        .busy(busy), .done(done), .halted_ok(halted_ok), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: PE imem written by the controller, PE fetching sequentially while released.
    logic [31:0] pe_mem [0:DEPTH-1];
    int pc = 0;
    int wr_count = 0;
    initial for (int i = 0; i < DEPTH; i++) pe_mem[i] = NOP;
    always @(posedge clk) if (imem_we) begin
        pe_mem[imem_waddr] <= imem_wdata;
        wr_count <= wr_count + 1;
    end
    always @(posedge clk or negedge pe_rst) begin
        if (!pe_rst) pc <= 0;
        else         pc <= pc + 1;
    end
    assign pe_instr = (pc < DEPTH) ? pe_mem[pc] : NOP;

    // Reference model of the run sequencer.
    int m_phase = P_IDLE, m_addr = 0, m_count = 0;
    bit m_h = 1'b0, m_to = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= P_IDLE; m_addr <= 0; m_count <= 0; m_h <= 1'b0; m_to <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (start) begin
                    m_phase <= P_LOAD; m_addr <= 0; m_count <= 0; m_h <= 1'b0; m_to <= 1'b0;
                end
                P_LOAD: if (prog_if.prog_valid) begin
                    if (prog_if.prog_last || m_addr == DEPTH - 1) m_phase <= P_RUN;
                    if (m_addr < DEPTH - 1) m_addr <= m_addr + 1;
                end
                P_RUN: begin
                    m_count <= (m_count < CMAX) ? m_count + 1 : m_count;
                    if (pe_instr == HALT) begin
                        m_h <= 1'b1; m_phase <= P_DONE;
                    end else if (WD && max_cycles != 0 && m_count + 1 == int'(max_cycles)) begin
                        m_to <= 1'b1; m_phase <= P_DONE;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("pe_rst",      {31'b0, pe_rst},     {31'b0, m_phase == P_RUN});
        chk("busy",        {31'b0, busy},       {31'b0, m_phase == P_LOAD || m_phase == P_RUN});
        chk("done",        {31'b0, done},       {31'b0, m_phase == P_DONE});
        chk("halted_ok",   {31'b0, halted_ok},  {31'b0, m_h});
        chk("timeout",     {31'b0, timeout},    {31'b0, m_to});
        chk("cycle_count", {16'b0, cycle_count}, 32'(m_count));
        chk("prog_ready",  {31'b0, prog_if.prog_ready}, {31'b0, m_phase == P_LOAD});
        chk("imem_we",     {31'b0, imem_we},    {31'b0, m_phase == P_LOAD && prog_if.prog_valid});
        chk("imem_waddr",  {29'b0, imem_waddr}, 32'(m_addr));
        chk("imem_wdata",  imem_wdata, (m_phase == P_LOAD) ? prog_if.prog_data : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; tick(); rst = 1'b1; tick();
    endtask

    logic [31:0] prog [0:DEPTH-1];

    task automatic load(input int n, input bit use_last, input int stall_pct, input bit rand_start);
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 3 && $urandom_range(99) < stall_pct; s++) begin
                prog_if.prog_valid = 1'b0;
                prog_if.prog_data  = $urandom;
                tick();
            end
            prog_if.prog_valid = 1'b1;
            prog_if.prog_data  = prog[i];
            prog_if.prog_last  = use_last && (i == n - 1);
            start = rand_start && ($urandom_range(3) == 0);
            tick();
        end
        prog_if.prog_valid = 1'b0;
        prog_if.prog_last  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = done;
        end
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = NOP;
        return w;
    endfunction

    initial begin
        bit seen;
        int w0;
        prog_if.prog_valid = 1'b0;
        prog_if.prog_data  = '0;
        prog_if.prog_last  = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_pe_rst", {31'b0, pe_rst}, 32'd0);
        chk("rst_busy",   {31'b0, busy},   32'd0);
        chk("rst_done",   {31'b0, done},   32'd0);
        chk("rst_count",  {16'b0, cycle_count}, 32'd0);
        rst = 1'b1; tick();

        // Three-word program ending in ecall.
        prog[0] = 32'h0050_0093; prog[1] = 32'h0030_8113; prog[2] = HALT;
        w0 = wr_count;
        do_start();
        load(3, 1'b1, 0, 1'b0);
        wait_done(20, seen);
        chk("t2_done_seen", {31'b0, seen}, 32'd1);
        chk("t2_halted", {31'b0, halted_ok}, 32'd1);
        chk("t2_timeout", {31'b0, timeout}, 32'd0);
        chk("t2_count", {16'b0, cycle_count}, 32'd3);
        chk("t2_writes", 32'(wr_count - w0), 32'd3);
        chk("t2_mem0", pe_mem[0], 32'h0050_0093);
        chk("t2_mem1", pe_mem[1], 32'h0030_8113);
        chk("t2_mem2", pe_mem[2], HALT);

        // Stalled load: valid 1,0,1.
        w0 = wr_count;
        do_start();
        prog_if.prog_valid = 1'b1; prog_if.prog_data = 32'h0010_0093; tick();
        prog_if.prog_valid = 1'b0; prog_if.prog_data = 32'hDEAD_BEEF; tick();
        prog_if.prog_valid = 1'b1; prog_if.prog_data = HALT; prog_if.prog_last = 1'b1; tick();
        prog_if.prog_valid = 1'b0; prog_if.prog_last = 1'b0;
        chk("t3_writes", 32'(wr_count - w0), 32'd2);
        chk("t3_mem1", pe_mem[1], HALT);
        wait_done(20, seen);
        chk("t3_count", {16'b0, cycle_count}, 32'd2);

        // Full-depth stream without prog_last, then reset mid-run.
        for (int i = 0; i < DEPTH; i++) prog[i] = rand_insn();
        w0 = wr_count;
        do_start();
        load(DEPTH, 1'b0, 0, 1'b0);
        prog_if.prog_valid = 1'b1;
        repeat (4) tick();
        prog_if.prog_valid = 1'b0;
        chk("t4_writes", 32'(wr_count - w0), 32'(DEPTH));
        chk("t4_mem0", pe_mem[0], prog[0]);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        chk("t4_count", {16'b0, cycle_count}, 32'd4);
        rst = 1'b0;
        #1;
        chk("t6_pe_rst", {31'b0, pe_rst}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_count", {16'b0, cycle_count}, 32'd0);
        tick(); rst = 1'b1; tick();
        chk("t6_mem3_kept", pe_mem[3], prog[3]);
        prog[0] = HALT;
        do_start();
        load(1, 1'b1, 0, 1'b0);
        wait_done(20, seen);
        chk("t6_restart_count", {16'b0, cycle_count}, 32'd1);

        // Watchdog.
        for (int i = 0; i < DEPTH; i++) prog[i] = rand_insn();
        max_cycles = 16'd10;
        do_start();
        load(DEPTH, 1'b0, 0, 1'b0);
`ifdef PE_WATCHDOG_EN
        wait_done(40, seen);
        chk("t5_done_seen", {31'b0, seen}, 32'd1);
        chk("t5_timeout", {31'b0, timeout}, 32'd1);
        chk("t5_halted", {31'b0, halted_ok}, 32'd0);
        chk("t5_count", {16'b0, cycle_count}, 32'd10);
        prog[3] = HALT;
        max_cycles = 16'd4;
        do_start();
        load(DEPTH, 1'b0, 0, 1'b0);
        wait_done(20, seen);
        chk("t5_tie_halted", {31'b0, halted_ok}, 32'd1);
        chk("t5_tie_timeout", {31'b0, timeout}, 32'd0);
        chk("t5_tie_count", {16'b0, cycle_count}, 32'd4);
`else
        repeat (30) tick();
        chk("t5_busy", {31'b0, busy}, 32'd1);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_count", {16'b0, cycle_count}, 32'd30);
        do_reset();
`endif

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            int n, hp;
            bit use_last;
            use_last = ($urandom_range(3) != 0);
            n  = use_last ? int'($urandom_range(DEPTH, 1)) : DEPTH;
            hp = ($urandom_range(9) < 7) ? int'($urandom_range(n - 1, 0)) : -1;
            for (int i = 0; i < n; i++) prog[i] = (i == hp) ? HALT : rand_insn();
            max_cycles = 16'($urandom_range(15, 0));
            do_start();
            load(n, use_last, 30, 1'b1);
            wait_done(40, seen);
            if (!seen) do_reset();
            else repeat ($urandom_range(2, 0)) tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end
endmodule
